// File: rtl/fma_pkg.sv
// Shared definitions for the FMA normalisation shifter: lane packing modes,
// lane geometry and the per-lane shift decode used by stage 1.
package fma_pkg;

    localparam int FMA_MW = 106;
    localparam int FMA_PW = 7;
    localparam logic [FMA_PW-1:0] FMA_ZPOS = 7'd127;

    localparam logic [1:0] MODE_DP  = 2'b00;
    localparam logic [1:0] MODE_SP  = 2'b01;
    localparam logic [1:0] MODE_HP  = 2'b10;
    localparam logic [1:0] MODE_RSV = 2'b11;

    // Lane widths for the three packings.
    localparam int LANE_W_DP = 106;
    localparam int LANE_W_SP = 53;
    localparam int LANE_W_HP = 26;

    // MSB index of lane 0 in each packing; lane k sits one lane width lower.
    // HP leaves the top two bits of the datapath unused.
    localparam int LANE_MSB_DP = 105;
    localparam int LANE_MSB_SP = 105;
    localparam int LANE_MSB_HP = 103;

    typedef struct packed {
        logic [FMA_PW-1:0] shamt;
        logic              zero;
        logic              err;
    } lane_dec_t;

    // Turns a leading-one position into a shift amount for one lane.
    // Lanes that do not exist in the given mode decode to all zeros; an empty
    // lane or an out-of-range position yields a zero lane with shamt 0.
    function automatic lane_dec_t lane_shamt(input logic [1:0]        mode,
                                             input int                lane,
                                             input logic [FMA_PW-1:0] pos,
                                             input logic [FMA_PW-1:0] zpos = FMA_ZPOS);
        lane_dec_t r;
        int        width;
        r = '0;
        case (mode)
            MODE_SP: width = (lane < 2) ? LANE_W_SP : 0;
            MODE_HP: width = (lane < 4) ? LANE_W_HP : 0;
            default: width = (lane == 0) ? LANE_W_DP : 0;
        endcase
        if (width != 0) begin
            if (pos == zpos) begin
                r.zero = 1'b1;
            end else if (int'(pos) >= width) begin
                r.zero = 1'b1;
                r.err  = 1'b1;
            end else begin
                r.shamt = pos;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fma_lane_lshift.sv
// Single-lane left barrel shifter with zero fill. A lane flagged as zero
// produces all zeros regardless of its input bits.
module fma_lane_lshift #(
    parameter int W  = 53,
    parameter int SW = 7
) (
    input  logic [W-1:0]  data_i,
    input  logic [SW-1:0] shamt_i,
    input  logic          zero_i,
    output logic [W-1:0]  data_o
);

    // Shift the lane left by the decoded amount, or blank it if empty.
    always_comb begin
        data_o = '0;
        if (!zero_i) begin
            data_o = data_i << shamt_i;
        end
    end

endmodule

// File: rtl/fma_norm_shift.sv
// Normalisation left-shifter for the multi-precision FMA datapath.
// Stage 1 decodes per-lane shift amounts from the LOD positions, stage 2
// performs the lane-local barrel shifts. Valid/ready handshake throughout.
module fma_norm_shift
    import fma_pkg::*;
#(
    parameter int              MW   = FMA_MW,
    parameter int              PW   = FMA_PW,
    parameter logic [PW-1:0]   ZPOS = FMA_ZPOS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_mode,
    input  logic [MW-1:0]     in_mant,
    input  logic [4*PW-1:0]   in_lopos,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MW-1:0]     out_mant,
    output logic [4*PW-1:0]   out_shamt,
    output logic [3:0]        out_zero,
    output logic [1:0]        out_mode,
    output logic              out_err
);

    // Stage 1 registers: decoded beat awaiting the shift.
    logic              s1_valid_q, s1_valid_d;
    logic [1:0]        s1_mode_q;
    logic [MW-1:0]     s1_mant_q;
    logic [4*PW-1:0]   s1_shamt_q;
    logic [3:0]        s1_zero_q;
    logic              s1_err_q;

    // Stage 2 registers: the normalised beat presented downstream.
    logic              s2_valid_q, s2_valid_d;
    logic [MW-1:0]     s2_mant_q;
    logic [4*PW-1:0]   s2_shamt_q;
    logic [3:0]        s2_zero_q;
    logic [1:0]        s2_mode_q;
    logic              s2_err_q;

    logic              s2_accept;
    logic              s1_load;
    logic              s2_load;

    logic [4*PW-1:0]   dec_shamt;
    logic [3:0]        dec_zero;
    logic              dec_err;

    logic [1:0]        s1_eff_mode;
    logic [MW-1:0]     dp_res;
    logic [LANE_W_SP-1:0] sp_res [2];
    logic [LANE_W_HP-1:0] hp_res [4];
    logic [MW-1:0]     shift_res;

    assign s2_accept = !s2_valid_q || out_ready;
    assign in_ready  = !s1_valid_q || s2_accept;
    assign s1_load   = in_valid && in_ready;
    assign s2_load   = s1_valid_q && s2_accept;

    // Decode every lane's shift amount; the reserved mode is treated as DP.
    always_comb begin
        logic [1:0] dmode;
        lane_dec_t  ld;
        dmode     = (in_mode == MODE_RSV) ? MODE_DP : in_mode;
        dec_err   = (in_mode == MODE_RSV);
        dec_shamt = '0;
        dec_zero  = '0;
        for (int k = 0; k < 4; k++) begin
            ld = lane_shamt(dmode, k, in_lopos[PW*k +: PW], ZPOS);
            dec_shamt[PW*k +: PW] = ld.shamt;
            dec_zero[k]           = ld.zero;
            dec_err               = dec_err | ld.err;
        end
    end

    // Next-state for the stage valids: a stage refills whenever it moves on.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (s2_accept) begin
            s2_valid_d = s1_valid_q;
        end
    end

    // Stage 1 capture of the incoming beat and its decoded lane info.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= '0;
            s1_mant_q  <= '0;
            s1_shamt_q <= '0;
            s1_zero_q  <= '0;
            s1_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (s1_load) begin
                s1_mode_q  <= in_mode;
                s1_mant_q  <= in_mant;
                s1_shamt_q <= dec_shamt;
                s1_zero_q  <= dec_zero;
                s1_err_q   <= dec_err;
            end
        end
    end

    assign s1_eff_mode = (s1_mode_q == MODE_RSV) ? MODE_DP : s1_mode_q;

    fma_lane_lshift #(.W(LANE_W_DP), .SW(PW)) u_dp (
        .data_i  (s1_mant_q),
        .shamt_i (s1_shamt_q[PW-1:0]),
        .zero_i  (s1_zero_q[0]),
        .data_o  (dp_res)
    );

    for (genvar k = 0; k < 2; k++) begin : g_sp
        fma_lane_lshift #(.W(LANE_W_SP), .SW(PW)) u_sp (
            .data_i  (s1_mant_q[LANE_MSB_SP - LANE_W_SP*k -: LANE_W_SP]),
            .shamt_i (s1_shamt_q[PW*k +: PW]),
            .zero_i  (s1_zero_q[k]),
            .data_o  (sp_res[k])
        );
    end

    for (genvar k = 0; k < 4; k++) begin : g_hp
        fma_lane_lshift #(.W(LANE_W_HP), .SW(PW)) u_hp (
            .data_i  (s1_mant_q[LANE_MSB_HP - LANE_W_HP*k -: LANE_W_HP]),
            .shamt_i (s1_shamt_q[PW*k +: PW]),
            .zero_i  (s1_zero_q[k]),
            .data_o  (hp_res[k])
        );
    end

    // Pick the lane packing matching this beat's mode; HP leaves the top two bits clear.
    always_comb begin
        shift_res = dp_res;
        case (s1_eff_mode)
            MODE_SP: shift_res = {sp_res[0], sp_res[1]};
            MODE_HP: shift_res = {2'b00, hp_res[0], hp_res[1], hp_res[2], hp_res[3]};
            default: shift_res = dp_res;
        endcase
    end

    // Stage 2 holds the result until downstream takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_mant_q  <= '0;
            s2_shamt_q <= '0;
            s2_zero_q  <= '0;
            s2_mode_q  <= '0;
            s2_err_q   <= 1'b0;
        end else begin
            s2_valid_q <= s2_valid_d;
            if (s2_load) begin
                s2_mant_q  <= shift_res;
                s2_shamt_q <= s1_shamt_q;
                s2_zero_q  <= s1_zero_q;
                s2_mode_q  <= s1_mode_q;
                s2_err_q   <= s1_err_q;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_mant  = s2_mant_q;
    assign out_shamt = s2_shamt_q;
    assign out_zero  = s2_zero_q;
    assign out_mode  = s2_mode_q;
    assign out_err   = s2_err_q;

endmodule

// File: tb/tb_fma_norm_shift.sv
// Self-checking bench for fma_norm_shift: directed beats with hand-derived
// expectations, a random stream under backpressure, and a mid-flight reset.
module tb_fma_norm_shift;

    typedef struct packed {
        logic [105:0] mant;
        logic [27:0]  shamt;
        logic [3:0]   zero;
        logic [1:0]   mode;
        logic         err;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_mode;
    logic [105:0] in_mant;
    logic [27:0]  in_lopos;
    logic         out_valid;
    logic         out_ready;
    logic [105:0] out_mant;
    logic [27:0]  out_shamt;
    logic [3:0]   out_zero;
    logic [1:0]   out_mode;
    logic         out_err;

    int    assertCount = 0;
    int    failCount   = 0;
    beat_t expQ[$];

    logic         stalled = 1'b0;
    logic [105:0] heldMant;
    logic [36:0]  heldRest;

    fma_norm_shift dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_mant   (in_mant),
        .in_lopos  (in_lopos),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mant  (out_mant),
        .out_shamt (out_shamt),
        .out_zero  (out_zero),
        .out_mode  (out_mode),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t mk(input logic [105:0] m, input logic [27:0] s,
                                 input logic [3:0] z, input logic [1:0] md, input logic e);
        beat_t b;
        b.mant = m; b.shamt = s; b.zero = z; b.mode = md; b.err = e;
        return b;
    endfunction

    // Bit-by-bit reference for a beat, walking each lane of the packing.
    function automatic beat_t expModel(input logic [1:0] mode, input logic [105:0] mant,
                                       input logic [27:0] lopos);
        beat_t e;
        int    nl, w, top, msb, lsb, p;
        logic [1:0] eff;
        e = '0;
        e.mode = mode;
        e.err  = (mode == 2'b11);
        eff = (mode == 2'b11) ? 2'b00 : mode;
        nl  = (eff == 2'b00) ? 1 : (eff == 2'b01) ? 2 : 4;
        w   = (eff == 2'b00) ? 106 : (eff == 2'b01) ? 53 : 26;
        top = (eff == 2'b10) ? 103 : 105;
        for (int l = 0; l < nl; l++) begin
            msb = top - w*l;
            lsb = msb - w + 1;
            p   = int'(lopos[7*l +: 7]);
            if (p == 127) begin
                e.zero[l] = 1'b1;
            end else if (p >= w) begin
                e.zero[l] = 1'b1;
                e.err     = 1'b1;
            end else begin
                e.shamt[7*l +: 7] = 7'(p);
                for (int b = p; b < w; b++) begin
                    e.mant[lsb+b] = mant[lsb+b-p];
                end
            end
        end
        return e;
    endfunction

    // Present one beat at a negedge, wait (bounded) for acceptance, record its expectation.
    task automatic applyStimulus(input logic [1:0] md, input logic [105:0] m,
                                 input logic [27:0] lp, input beat_t exp);
        int waitCnt;
        in_valid = 1'b1;
        in_mode  = md;
        in_mant  = m;
        in_lopos = lp;
        waitCnt  = 0;
        while (!in_ready && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!in_ready) begin
            checkOutput("acceptTimeout", 128'(in_ready), 128'd1);
            in_valid = 1'b0;
        end else begin
            expQ.push_back(exp);
            @(negedge clk);
        end
    endtask

    task automatic waitDrain();
        int cnt;
        cnt = 0;
        while (expQ.size() != 0 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("drainQueue", 128'(expQ.size()), 128'd0);
    endtask

    // Scoreboard: compare each delivered beat, and hold-stability while stalled.
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled && out_valid) begin
                checkOutput("stallMant", 128'(out_mant), 128'(heldMant));
                checkOutput("stallRest", 128'({out_shamt, out_zero, out_mode, out_err}), 128'(heldRest));
            end
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedBeat", 128'(out_valid), 128'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("outMant",  128'(out_mant),  128'(e.mant));
                    checkOutput("outShamt", 128'(out_shamt), 128'(e.shamt));
                    checkOutput("outZero",  128'(out_zero),  128'(e.zero));
                    checkOutput("outMode",  128'(out_mode),  128'(e.mode));
                    checkOutput("outErr",   128'(out_err),   128'(e.err));
                end
            end
            stalled  = out_valid && !out_ready;
            heldMant = out_mant;
            heldRest = {out_shamt, out_zero, out_mode, out_err};
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0]   rm;
        logic [105:0] rmant;
        logic [27:0]  rlp;
        int           w, nl;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_mode   = '0;
        in_mant   = '0;
        in_lopos  = '0;
        out_ready = 1'b1;

        // Reset state.
        repeat (2) @(negedge clk);
        checkOutput("rstValid", 128'(out_valid), 128'd0);
        checkOutput("rstMant",  128'(out_mant),  128'd0);
        checkOutput("rstShamt", 128'(out_shamt), 128'd0);
        checkOutput("rstZero",  128'(out_zero),  128'd0);
        checkOutput("rstMode",  128'(out_mode),  128'd0);
        checkOutput("rstErr",   128'(out_err),   128'd0);
        rst_n = 1'b1;
        #1 checkOutput("rstInReady", 128'(in_ready), 128'd1);
        @(negedge clk);

        // Directed beats, back-to-back with mixed modes.
        applyStimulus(2'b00, 106'd1 << 100, 28'd5,
                      mk(106'd1 << 105, 28'd5, 4'b0000, 2'b00, 1'b0));
        checkOutput("latencyFirst", 128'(out_valid), 128'd0);
        applyStimulus(2'b01, (106'd1 << 60) | 106'd1, (28'd52 << 7) | 28'd45,
                      mk((106'd1 << 105) | (106'd1 << 52), (28'd52 << 7) | 28'd45, 4'b0000, 2'b01, 1'b0));
        applyStimulus(2'b10, (106'd1 << 105) | (106'd1 << 100) | (106'd1 << 51) | 106'd1,
                      (28'd25 << 21) | (28'd127 << 7) | 28'd3,
                      mk((106'd1 << 103) | (106'd1 << 51) | (106'd1 << 25),
                         (28'd25 << 21) | 28'd3, 4'b0010, 2'b10, 1'b0));
        applyStimulus(2'b01, (106'd1 << 100) | (106'd1 << 52), 28'd60,
                      mk(106'd1 << 52, 28'd0, 4'b0001, 2'b01, 1'b1));
        applyStimulus(2'b11, 106'd1 << 100, 28'd5,
                      mk(106'd1 << 105, 28'd5, 4'b0000, 2'b11, 1'b1));
        applyStimulus(2'b00, 106'd1, (28'd127 << 21) | (28'd50 << 14) | (28'd3 << 7) | 28'd105,
                      mk(106'd1 << 105, 28'd105, 4'b0000, 2'b00, 1'b0));
        applyStimulus(2'b00, 106'd1, 28'd106,
                      mk(106'd0, 28'd0, 4'b0001, 2'b00, 1'b1));
        applyStimulus(2'b00, 106'd0, 28'd127,
                      mk(106'd0, 28'd0, 4'b0001, 2'b00, 1'b0));
        applyStimulus(2'b10, (106'd1 << 103) | (106'd1 << 77) | (106'd1 << 51) | 106'd1, 28'd26 << 21,
                      mk((106'd1 << 103) | (106'd1 << 77) | (106'd1 << 51), 28'd0, 4'b1000, 2'b10, 1'b1));
        in_valid = 1'b0;
        waitDrain();

        // Random stream of 6 beats with a 4-cycle stall in the middle.
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    rm    = 2'($urandom_range(0, 2));
                    rmant = {$urandom, $urandom, $urandom, $urandom};
                    w     = (rm == 2'b00) ? 106 : (rm == 2'b01) ? 53 : 26;
                    nl    = (rm == 2'b00) ? 1 : (rm == 2'b01) ? 2 : 4;
                    rlp   = '0;
                    for (int l = 0; l < nl; l++) begin
                        rlp[7*l +: 7] = ($urandom_range(0, 7) == 0) ? 7'd127 : 7'($urandom_range(0, w-1));
                    end
                    applyStimulus(rm, rmant, rlp, expModel(rm, rmant, rlp));
                end
                in_valid = 1'b0;
            end
            begin
                @(posedge clk);
                @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                @(negedge clk);
                checkOutput("inReadyStall", 128'(in_ready), 128'd0);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        waitDrain();

        // Reset with two beats in flight, then check fresh latency.
        rmant = 106'h2_0000_0000_0000_1234_5678_9abc;
        applyStimulus(2'b01, rmant, (28'd10 << 7) | 28'd4, expModel(2'b01, rmant, (28'd10 << 7) | 28'd4));
        applyStimulus(2'b10, rmant, (28'd1 << 21) | (28'd2 << 14) | (28'd127 << 7) | 28'd7,
                      expModel(2'b10, rmant, (28'd1 << 21) | (28'd2 << 14) | (28'd127 << 7) | 28'd7));
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midRstValid", 128'(out_valid), 128'd0);
        checkOutput("midRstMant",  128'(out_mant),  128'd0);
        expQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1 checkOutput("postRstInReady", 128'(in_ready), 128'd1);
        @(negedge clk);
        applyStimulus(2'b00, 106'd1 << 50, 28'd55, mk(106'd1 << 105, 28'd55, 4'b0000, 2'b00, 1'b0));
        in_valid = 1'b0;
        checkOutput("postRstEarly", 128'(out_valid), 128'd0);
        @(negedge clk);
        checkOutput("postRstOnTime", 128'(out_valid), 128'd1);
        waitDrain();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
